// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC and issues one word fetch at a time over req/gnt/rvalid. IF/ID is valid one cycle after rvalid.
// Backpressure: a stall holds IF/ID, and a response that arrives during the stall waits in a 1-entry buffer.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_misalign
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic        drop;
  logic [31:0] hold_buf;

  logic        load_rsp;
  logic        load_buf;
  logic        load_en;
  logic [31:0] load_dat;

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  // A response goes straight to IF/ID when decode can take it; otherwise it parks in hold_buf.
  always_comb begin
    load_rsp = 1'b0;
    load_buf = 1'b0;
    if (!redirect) begin
      load_rsp = (state == WAIT) && imem_rvalid && !drop && (!if_valid || !stall);
      load_buf = (state == HOLD) && !stall;
    end
    load_en  = load_rsp || load_buf;
    load_dat = load_buf ? hold_buf : imem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      hold_buf    <= 32'd0;
      if_valid    <= 1'b0;
      if_inst     <= NOP_INST;
      if_pc       <= 32'd0;
      if_pc_plus4 <= 32'd4;
      if_misalign <= 1'b0;
    end else begin
      if_misalign <= 1'b0;
      if (redirect) begin
        pc          <= {redirect_pc[31:2], 2'b00};
        if_valid    <= 1'b0;
        if_inst     <= NOP_INST;
        if_misalign <= |redirect_pc[1:0];
        case (state)
          REQ: begin
            if (imem_gnt) begin
              state <= WAIT;
              drop  <= 1'b1;
            end else begin
              state <= REQ;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              state <= REQ;
              drop  <= 1'b0;
            end else begin
              drop  <= 1'b1;
            end
          end
          default: state <= REQ;
        endcase
      end else begin
        case (state)
          IDLE: state <= REQ;
          REQ: begin
            if (imem_gnt) state <= WAIT;
          end
          WAIT: begin
            if (imem_rvalid) begin
              if (drop) begin
                // Stale response from before a redirect; pc already holds the target.
                drop  <= 1'b0;
                state <= REQ;
              end else if (load_rsp) begin
                state <= REQ;
              end else begin
                hold_buf <= imem_rdata;
                state    <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!stall) state <= REQ;
          end
          default: state <= IDLE;
        endcase

        if (load_en) begin
          if_valid    <= 1'b1;
          if_inst     <= load_dat;
          if_pc       <= pc;
          if_pc_plus4 <= pc + 32'd4;
          pc          <= pc + 32'd4;
        end else if (if_valid && !stall) begin
          if_valid <= 1'b0;
          if_inst  <= NOP_INST;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a default-PC instance for the main scenarios and a top-of-memory instance for wrap and reset.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_misalign;

  logic        reset2 = 1'b0;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_gnt2 = 1'b0;
  logic        imem_rvalid2 = 1'b0;
  logic [31:0] imem_rdata2 = 32'd0;
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'd0;
  logic        stall2 = 1'b0;
  logic        if_valid2;
  logic [31:0] if_inst2;
  logic [31:0] if_pc2;
  logic [31:0] if_pc_plus42;
  logic        if_misalign2;

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_misalign(if_misalign)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_top (
    .clk(clk), .reset(reset2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .redirect(redirect2), .redirect_pc(redirect_pc2), .stall(stall2),
    .if_valid(if_valid2), .if_inst(if_inst2), .if_pc(if_pc2),
    .if_pc_plus4(if_pc_plus42), .if_misalign(if_misalign2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick(); tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", if_valid); end
    checks++; if (if_inst !== 32'h0000_0013) begin errors++; $display("FAIL reset_inst: got %h want 00000013", if_inst); end
    checks++; if (if_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", if_pc); end
    checks++; if (if_pc_plus4 !== 32'd4) begin errors++; $display("FAIL reset_pc4: got %h want 4", if_pc_plus4); end
    checks++; if (if_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %0b want 0", if_misalign); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", imem_req); end
  endtask

  task automatic test_first_fetch;
    reset = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %0b want 1", imem_req); end
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL first_addr: got %h want 0", imem_addr); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wait_req: got %0b want 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL wait_valid: got %0b want 0", if_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %0b want 1", if_valid); end
    checks++; if (if_inst !== 32'h0050_0093) begin errors++; $display("FAIL first_inst: got %h want 00500093", if_inst); end
    checks++; if (if_pc !== 32'd0) begin errors++; $display("FAIL first_pc: got %h want 0", if_pc); end
    checks++; if (if_pc_plus4 !== 32'd4) begin errors++; $display("FAIL first_pc4: got %h want 4", if_pc_plus4); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin errors++; $display("FAIL next_addr: got req=%0b addr=%h want req=1 addr=4", imem_req, imem_addr); end
  endtask

  task automatic test_stall;
    stall = 1'b1; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'd0) begin errors++; $display("FAIL stall1: got valid=%0b pc=%h want 1/0", if_valid, if_pc); end
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_inst !== 32'h0050_0093) begin errors++; $display("FAIL stall2: got valid=%0b pc=%h inst=%h want 1/0/00500093", if_valid, if_pc, if_inst); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req: got %0b want 0", imem_req); end
    tick();
    stall = 1'b0;
    checks++; if (if_pc !== 32'd0 || imem_req !== 1'b0) begin errors++; $display("FAIL stall3: got pc=%h req=%0b want 0/0", if_pc, imem_req); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'd4 || if_inst !== 32'h00A0_0113) begin errors++; $display("FAIL unhold: got valid=%0b pc=%h inst=%h want 1/4/00a00113", if_valid, if_pc, if_inst); end
    checks++; if (if_pc_plus4 !== 32'd8) begin errors++; $display("FAIL unhold_pc4: got %h want 8", if_pc_plus4); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd8) begin errors++; $display("FAIL unhold_addr: got req=%0b addr=%h want 1/8", imem_req, imem_addr); end
    tick();
    checks++; if (if_valid !== 1'b0 || if_inst !== 32'h0000_0013) begin errors++; $display("FAIL consume: got valid=%0b inst=%h want 0/00000013", if_valid, if_inst); end
    checks++; if (imem_addr !== 32'd8 || imem_req !== 1'b1) begin errors++; $display("FAIL req_stable: got req=%0b addr=%h want 1/8", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL redir_wait: got valid=%0b req=%0b want 0/0", if_valid, imem_req); end
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b0 || if_inst !== 32'h0000_0013) begin errors++; $display("FAIL stale_drop: got valid=%0b inst=%h want 0/00000013", if_valid, if_inst); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr: got req=%0b addr=%h want 1/100", imem_req, imem_addr); end
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stale_late: got valid=%0b want 0", if_valid); end
  endtask

  task automatic test_redirect_stall;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin errors++; $display("FAIL pre_flush: got valid=%0b pc=%h want 1/100", if_valid, if_pc); end
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0; stall = 1'b0;
    checks++; if (if_valid !== 1'b0 || if_inst !== 32'h0000_0013) begin errors++; $display("FAIL flush_wins: got valid=%0b inst=%h want 0/00000013", if_valid, if_inst); end
    checks++; if (imem_addr !== 32'h200 || if_misalign !== 1'b0) begin errors++; $display("FAIL flush_addr: got addr=%h mis=%0b want 200/0", imem_addr, if_misalign); end
  endtask

  task automatic test_misalign;
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    checks++; if (if_misalign !== 1'b1) begin errors++; $display("FAIL misalign_pulse: got %0b want 1", if_misalign); end
    checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL misalign_addr: got addr=%h req=%0b want 100/1", imem_addr, imem_req); end
    tick();
    checks++; if (if_misalign !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %0b want 0", if_misalign); end
  endtask

  task automatic test_wrap;
    checks++; if (imem_addr2 !== 32'hFFFF_FFFC || imem_req2 !== 1'b0) begin errors++; $display("FAIL top_reset: got addr=%h req=%0b want fffffffc/0", imem_addr2, imem_req2); end
    reset2 = 1'b1;
    tick();
    checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL top_req: got req=%0b addr=%h want 1/fffffffc", imem_req2, imem_addr2); end
    imem_gnt2 = 1'b1;
    tick();
    imem_gnt2 = 1'b0;
    imem_rvalid2 = 1'b1; imem_rdata2 = 32'h0010_0093;
    tick();
    imem_rvalid2 = 1'b0;
    checks++; if (if_valid2 !== 1'b1 || if_pc2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got valid=%0b pc=%h want 1/fffffffc", if_valid2, if_pc2); end
    checks++; if (if_pc_plus42 !== 32'd0) begin errors++; $display("FAIL wrap_pc4: got %h want 0", if_pc_plus42); end
    checks++; if (imem_addr2 !== 32'd0 || imem_req2 !== 1'b1) begin errors++; $display("FAIL wrap_addr: got addr=%h req=%0b want 0/1", imem_addr2, imem_req2); end
    imem_gnt2 = 1'b1;
    tick();
    imem_gnt2 = 1'b0;
    reset2 = 1'b0;
    tick();
    checks++; if (if_valid2 !== 1'b0 || imem_req2 !== 1'b0 || imem_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wait_reset: got valid=%0b req=%0b addr=%h want 0/0/fffffffc", if_valid2, imem_req2, imem_addr2); end
    reset2 = 1'b1; imem_rvalid2 = 1'b1; imem_rdata2 = 32'hDEAD_BEEF;
    tick();
    imem_rvalid2 = 1'b0;
    checks++; if (if_valid2 !== 1'b0 || if_inst2 !== 32'h0000_0013 || if_pc2 !== 32'd0) begin errors++; $display("FAIL late_rvalid: got valid=%0b inst=%h pc=%h want 0/00000013/0", if_valid2, if_inst2, if_pc2); end
    checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL restart: got req=%0b addr=%h want 1/fffffffc", imem_req2, imem_addr2); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_stall();
    test_misalign();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the RV32I core. It sits directly upstream of the ID control decoder.
- Owns the PC and issues word fetches to instruction memory over a request/grant/response handshake.
- Presents a registered IF/ID word (instruction, PC, PC+4, valid) to decode.
- Supports back-pressure (stall) and control-flow redirect/flush from EX (branch/JAL/JALR).

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0013, ADDI x0,x0,0; driven on if_inst whenever if_valid=0.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- imem_req  out  1  fetch request
- imem_addr  out  32  word-aligned fetch address (= pc)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  fetched instruction
- redirect  in  1  taken branch/jump; flush and reload PC
- redirect_pc  in  32  target address
- stall  in  1  decode cannot accept; hold IF/ID
- if_valid  out  1  IF/ID holds a live instruction
- if_inst  out  32  instruction to decoder
- if_pc  out  32  PC of if_inst
- if_pc_plus4  out  32  if_pc+4, modulo 2^32
- if_misalign  out  1  one-cycle pulse: redirect_pc[1:0]!=0

Behaviour:
- Reset (reset=0 at a clock edge), all outputs registered:
  - state=IDLE, pc=RESET_PC, drop=0.
  - if_valid=0, if_inst=NOP_INST, if_pc=0, if_pc_plus4=4, if_misalign=0.
  - imem_req=0 while in IDLE.
  - Reset mid-transaction discards everything; responses arriving in IDLE/REQ are ignored.
- States:
  - IDLE: goes to REQ the cycle after reset releases.
  - REQ: imem_req=1, imem_addr=pc. imem_gnt=1 -> WAIT.
  - WAIT: imem_req=0, waits for imem_rvalid. Only one request is outstanding at a time.
  - HOLD: response captured in a 1-entry buffer because IF/ID is stalled.
- WAIT, imem_rvalid=1, drop=0:
  - If IF/ID is free (if_valid=0 or stall=0): load if_inst=imem_rdata, if_pc=pc, if_pc_plus4=pc+4, if_valid=1; pc+=4; -> REQ.
  - Otherwise: buffer imem_rdata -> HOLD.
- HOLD, first cycle stall=0: load IF/ID from buffer, pc+=4, -> REQ.
- WAIT, imem_rvalid=1, drop=1: discard data, clear drop, -> REQ (pc already holds the target).
- Consumption: if_valid=1, stall=0, and no new load that cycle -> if_valid<=0, if_inst<=NOP_INST.
- Stall: if_valid=1, stall=1 -> if_inst/if_pc/if_pc_plus4/if_valid hold exactly.
- Redirect has priority over stall and all other events except reset:
  - Always: pc<=redirect_pc with [1:0] forced to 00; if_valid<=0; if_inst<=NOP_INST; if_misalign<=|redirect_pc[1:0].
  - IDLE/REQ without gnt: -> REQ (new address next cycle).
  - REQ with gnt same cycle: -> WAIT with drop=1.
  - WAIT without rvalid: drop<=1, stay WAIT.
  - WAIT with rvalid: discard data, drop stays 0, -> REQ.
  - HOLD: buffer discarded, -> REQ.
- Latency and throughput:
  - gnt at cycle t, rvalid at t+k (k>=1) -> if_valid=1 at t+k+1.
  - Best case one instruction per 2 cycles (gnt and rvalid each take one cycle).
- Wrap: pc 32'hFFFF_FFFC +4 -> 32'h0000_0000, no flag.
- imem_addr is stable while imem_req=1 until gnt; it changes mid-REQ only on redirect.

Test Plan:
- Reset then release; memory: gnt same cycle, rvalid next, rdata=32'h00500093 -> imem_addr=0 in the first REQ; if_valid=1 with if_inst=32'h00500093, if_pc=0, if_pc_plus4=4 on the cycle after rvalid; next imem_addr=4.
- Stall held for 3 cycles with one response arriving during the stall (rdata=32'h00A00113 at pc=4) -> IF/ID holds pc=0 for 3 cycles; no new imem_req while in HOLD; after stall drops, if_pc=4, if_inst=32'h00A00113; next imem_addr=8.
- Redirect to 32'h100 while in WAIT (rvalid two cycles later, rdata=32'hDEADBEEF) -> if_valid=0, response discarded, next imem_addr=32'h100, nothing reaches decode from the stale fetch.
- Redirect and stall in the same cycle with if_valid=1 -> flush wins: if_valid=0, if_inst=32'h00000013.
- redirect_pc=32'h0000_0102 -> if_misalign pulses 1 for exactly one cycle; imem_addr=32'h100.
- RESET_PC=32'hFFFF_FFFC, one fetch completes -> if_pc=32'hFFFF_FFFC, if_pc_plus4=0, next imem_addr=0; then assert reset while in WAIT -> IDLE, if_valid=0, pc=RESET_PC, late rvalid ignored.
